// File: rtl/rr_mux_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_arb
// Brief    : Round-robin, packet-locking arbiter driving a 2**N:1 valid/ready mux
// Revision : 1.0
// ============================================================================
module rr_mux_arb #(
    parameter int WIDTH = 32,
    parameter int N     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2**N-1:0]      req_valid,
    input  logic [WIDTH-1:0]     req_data [2**N],
    input  logic [2**N-1:0]      req_last,
    output logic [2**N-1:0]      req_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 grant_valid,
    output logic [N-1:0]         grant_idx
);

    localparam int c_NREQ = 2**N;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_grant_idx;
    logic [N-1:0]   r_ptr;

    logic           w_busy;
    logic           w_any;
    logic [N-1:0]   w_pick;
    logic [N-1:0]   w_cand;
    logic           w_done;

    assign w_busy = (r_state == ST_BUSY);

    // First valid requester at or after the pointer, wrapping modulo 2**N.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_cand = '0;
        for (int k = 0; k < c_NREQ; k++) begin
            w_cand = r_ptr + k[N-1:0];
            if (!w_any && req_valid[w_cand]) begin
                w_any  = 1'b1;
                w_pick = w_cand;
            end
        end
    end

    // Only the granted lane reaches the outputs, so X on idle lanes is masked.
    always_comb begin
        req_ready = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        if (w_busy) begin
            out_valid              = req_valid[r_grant_idx];
            out_data               = req_data[r_grant_idx];
            out_last               = req_last[r_grant_idx];
            req_ready[r_grant_idx] = out_ready;
        end
    end

    assign w_done      = out_valid && out_ready && out_last;
    assign grant_valid = w_busy;
    assign grant_idx   = r_grant_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_grant_idx <= '0;
            r_ptr       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant_idx <= w_pick;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_done) begin
                        r_ptr   <= r_grant_idx + 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_arb
// Brief    : Randomised and directed bench for rr_mux_arb against a behavioural model
// Revision : 1.0
// ============================================================================
module tb_rr_mux_arb;

    localparam int WIDTH = 32;
    localparam int N     = 2;
    localparam int NREQ  = 4;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [WIDTH-1:0]   req_data [NREQ];
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic               out_ready;
    logic               grant_valid;
    logic [N-1:0]       grant_idx;

    rr_mux_arb #(.WIDTH(WIDTH), .N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready),
        .grant_valid(grant_valid), .grant_idx(grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit do_cmp = 0;

    // Behavioural model: who holds the channel and who served last.
    bit               m_busy;
    int               m_gidx;
    int               m_ptr;
    int               m_grants[$];
    logic [WIDTH-1:0] m_beats[$];

    // Source models (stimulus side).
    int               rem[NREQ];
    int               pkts[NREQ];
    int               plen[NREQ];
    int               beat[NREQ];
    logic [WIDTH-1:0] base[NREQ];
    bit               bubble[NREQ];
    bit               toggle_rdy;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare();
        logic             e_ov, e_ol;
        logic [WIDTH-1:0] e_od;
        logic [NREQ-1:0]  e_rr;
        e_ov = 1'b0; e_ol = 1'b0; e_od = '0; e_rr = '0;
        if (m_busy) begin
            e_ov         = req_valid[m_gidx];
            e_od         = req_data[m_gidx];
            e_ol         = req_last[m_gidx];
            e_rr[m_gidx] = out_ready;
        end
        chk("out_valid", out_valid, e_ov);
        chk("out_data", out_data, e_od);
        chk("out_last", out_last, e_ol);
        chk("req_ready", req_ready, e_rr);
        chk("grant_valid", grant_valid, m_busy);
        chk("grant_idx", grant_idx, m_gidx);
    endtask

    task automatic model_update();
        if (!rst_n) begin
            m_busy = 0; m_gidx = 0; m_ptr = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (!m_busy && req_valid[i]) begin
                    m_busy = 1; m_gidx = i;
                    m_grants.push_back(i);
                end
            end
        end else if (req_valid[m_gidx] && out_ready) begin
            m_beats.push_back(req_data[m_gidx]);
            if (req_last[m_gidx]) begin
                m_busy = 0;
                m_ptr  = (m_gidx + 1) % NREQ;
            end
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (rem[i] > 0) begin
                req_valid[i] = !bubble[i];
                req_last[i]  = (rem[i] == 1);
                req_data[i]  = base[i] + WIDTH'(beat[i]);
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'bx;
                req_data[i]  = 'x;
            end
        end
    endtask

    task automatic load(int i, int len, int npk, logic [WIDTH-1:0] b);
        rem[i] = len; plen[i] = len; pkts[i] = npk; beat[i] = 0; base[i] = b;
    endtask

    task automatic clear_src();
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0; pkts[i] = 0; beat[i] = 0; bubble[i] = 0;
        end
    endtask

    task automatic cycle();
        logic [NREQ-1:0] hs;
        @(negedge clk);
        if (do_cmp) compare();
        hs = req_valid & req_ready & {NREQ{rst_n}};
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i] && rem[i] > 0) begin
                beat[i]++;
                rem[i]--;
                if (rem[i] == 0) begin
                    pkts[i]--;
                    if (pkts[i] > 0) begin
                        rem[i] = plen[i]; beat[i] = 0;
                    end
                end
            end
        end
        if (toggle_rdy) out_ready = ~out_ready;
        drive();
    endtask

    function automatic bit quiet();
        bit q;
        q = !m_busy;
        for (int i = 0; i < NREQ; i++) if (rem[i] > 0) q = 0;
        return q;
    endfunction

    task automatic wait_quiet(int budget, string name);
        int b = 0;
        while (!quiet() && b < budget) begin cycle(); b++; end
        chk(name, quiet(), 1);
    endtask

    task automatic wait_grants(int n, int budget, string name);
        int b = 0;
        while (m_grants.size() < n && b < budget) begin cycle(); b++; end
        chk(name, m_grants.size() >= n, 1);
    endtask

    task automatic wait_beats(int n, int budget, string name);
        int b = 0;
        while (m_beats.size() < n && b < budget) begin cycle(); b++; end
        chk(name, m_beats.size() >= n, 1);
    endtask

    task automatic clear_logs();
        m_grants.delete();
        m_beats.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq5[8];
        seq5 = '{0, 1, 2, 3, 0, 1, 2, 3};
        m_busy = 0; m_gidx = 0; m_ptr = 0;
        toggle_rdy = 0;
        rst_n = 1'b0;
        out_ready = 1'b0;
        clear_src();
        drive();
        @(posedge clk);
        #1;
        do_cmp = 1;
        cycle();
        rst_n = 1'b1;

        // Idle after reset
        for (int t = 0; t < 10; t++) begin
            cycle();
            chk("idle_out_valid", out_valid, 0);
            chk("idle_req_ready", req_ready, 0);
            chk("idle_grant_valid", grant_valid, 0);
            chk("idle_grant_idx", grant_idx, 0);
        end

        // Requesters 1 and 3 with single-beat packets
        clear_logs();
        out_ready = 1'b1;
        load(1, 1, 1, 32'h11111111);
        load(3, 1, 1, 32'h33333333);
        drive();
        wait_quiet(40, "s2_done_a");
        load(1, 1, 1, 32'h11111111);
        drive();
        wait_quiet(40, "s2_done_b");
        chk("s2_grant0", m_grants.size() > 0 ? m_grants[0] : -1, 1);
        chk("s2_grant1", m_grants.size() > 1 ? m_grants[1] : -1, 3);
        chk("s2_grant2", m_grants.size() > 2 ? m_grants[2] : -1, 1);
        chk("s2_beat0", m_beats.size() > 0 ? m_beats[0] : 0, 32'h11111111);
        chk("s2_beat1", m_beats.size() > 1 ? m_beats[1] : 0, 32'h33333333);

        // Three-beat packet from 2 under a toggling out_ready, req 0 waiting
        clear_logs();
        load(2, 3, 1, 32'hA0);
        load(0, 1, 1, 32'hB0);
        toggle_rdy = 1;
        drive();
        wait_quiet(60, "s3_done");
        toggle_rdy = 0;
        out_ready = 1'b1;
        drive();
        chk("s3_grant0", m_grants.size() > 0 ? m_grants[0] : -1, 2);
        chk("s3_grant1", m_grants.size() > 1 ? m_grants[1] : -1, 0);
        chk("s3_nbeats", m_beats.size(), 4);
        chk("s3_beat0", m_beats.size() > 0 ? m_beats[0] : 0, 32'hA0);
        chk("s3_beat1", m_beats.size() > 1 ? m_beats[1] : 0, 32'hA1);
        chk("s3_beat2", m_beats.size() > 2 ? m_beats[2] : 0, 32'hA2);

        // Holder 0 bubbles for 4 cycles while req 1 waits
        clear_logs();
        load(0, 3, 1, 32'hC0);
        drive();
        wait_grants(1, 20, "s4_grant_wait");
        load(1, 1, 1, 32'hD0);
        drive();
        wait_beats(1, 20, "s4_beat_wait");
        bubble[0] = 1;
        drive();
        for (int t = 0; t < 4; t++) begin
            #1;
            chk("s4_bubble_valid", out_valid, 0);
            chk("s4_bubble_gidx", grant_idx, 0);
            chk("s4_bubble_ready1", req_ready[1], 0);
            cycle();
        end
        bubble[0] = 0;
        drive();
        wait_quiet(40, "s4_done");
        chk("s4_grant0", m_grants.size() > 0 ? m_grants[0] : -1, 0);
        chk("s4_grant1", m_grants.size() > 1 ? m_grants[1] : -1, 1);
        chk("s4_beat3", m_beats.size() > 3 ? m_beats[3] : 0, 32'hD0);

        // All four continuously valid, pointer wraps
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        clear_logs();
        for (int i = 0; i < NREQ; i++) load(i, 1, 2, 32'h100 * (i + 1));
        drive();
        wait_quiet(60, "s5_done");
        for (int k = 0; k < 8; k++)
            chk("s5_grant_seq", m_grants.size() > k ? m_grants[k] : -1, seq5[k]);

        // Reset in the middle of a 4-beat packet from 3
        clear_logs();
        load(3, 4, 1, 32'hE0);
        drive();
        wait_beats(1, 20, "s6_beat_wait");
        chk("s6_holder", grant_idx, 3);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        clear_src();
        drive();
        #1;
        chk("s6_rst_valid", out_valid, 0);
        chk("s6_rst_ready", req_ready, 0);
        chk("s6_rst_grant_valid", grant_valid, 0);
        chk("s6_nbeats", m_beats.size(), 1);
        clear_logs();
        for (int i = 0; i < NREQ; i++) load(i, 1, 1, 32'hF0 + i);
        drive();
        wait_quiet(40, "s6_done");
        chk("s6_first_grant", m_grants.size() > 0 ? m_grants[0] : -1, 0);

        // Randomised traffic
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 3) == 0)
                    load(i, $urandom_range(1, 4), $urandom_range(1, 2), $urandom);
                bubble[i] = ($urandom_range(0, 4) == 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 399) != 0);
            drive();
            cycle();
            if (!rst_n) begin
                clear_src();
                drive();
            end
        end
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Round-robin, packet-locking arbiter that shares one WIDTH-bit output channel between 2**N valid/ready requesters.
- Internally it drives the select of a general 2**N-input mux.
- Used wherever several pipeline sources contend for a single downstream port, such as a shared writeback or memory request path.
- A grant is held from the first beat of a packet through the handshake of its last beat.

Parameters:
WIDTH, 32, data width of each requester and of the output
N, 2, select width; number of requesters = 2**N

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  2**N  per-requester beat valid
req_data  input  2**N x WIDTH (unpacked array [2**N])  per-requester beat data
req_last  input  2**N  per-requester last-beat-of-packet flag
req_ready  output  2**N  per-requester ready (one-hot or zero)
out_valid  output  1  shared channel valid
out_data  output  WIDTH  shared channel data
out_last  output  1  shared channel last flag
out_ready  input  1  downstream ready
grant_valid  output  1  a requester currently holds the channel
grant_idx  output  N  index of current holder

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n low at a clock edge):
  - state goes to IDLE, grant_valid=0, grant_idx=0, rr pointer ptr=0.
  - Outputs are combinationally forced to out_valid=0, out_last=0, out_data=0 and req_ready=0 while state is IDLE.
- State machine has two states, IDLE and BUSY.
- IDLE:
  - req_ready=0, out_valid=0, out_data=0, out_last=0, grant_valid=0.
  - If any req_valid bit is set, select the first set bit searching ptr, ptr+1, ... 2**N-1, 0, ... ptr-1 (modulo 2**N wrap).
  - Register that index into grant_idx and go to BUSY at the next edge.
  - If no bit is set, stay in IDLE.
  - Arbitration costs exactly 1 cycle. req_valid is sampled only in IDLE.
- BUSY:
  - grant_valid=1.
  - out_data = req_data[grant_idx], out_valid = req_valid[grant_idx], out_last = req_last[grant_idx]. These are combinational through the mux, with zero latency.
  - req_ready[grant_idx] = out_ready; all other req_ready bits are 0.
  - A beat transfers when out_valid && out_ready.
  - On a transfer with out_last=1: next state is IDLE and ptr <= grant_idx+1 (wraps mod 2**N).
  - Otherwise: stay in BUSY holding grant_idx.
- Bubbles: the holder may deassert req_valid mid-packet. The grant is held with out_valid=0 and no timeout, and other requesters are not serviced.
- Non-holders see req_ready=0 at all times, even if out_ready=1.
- Back-to-back packets: at least one IDLE cycle separates consecutive packets. Sustained throughput with single-beat packets is therefore 1 beat per 2 cycles.
- Single-beat packet: req_last=1 on the first beat. BUSY lasts one cycle if out_ready=1.
- Fairness: after a packet from index i completes, i has the lowest priority in the next arbitration. A requester continuously asserting valid is granted within 2**N arbitrations.
- Reset mid-packet:
  - the packet is abandoned and no beat is transferred on the reset edge;
  - the block returns to IDLE with ptr=0;
  - upstream and downstream are responsible for their own recovery.
- req_data and req_last of non-granted requesters are don't-care. X on them must not propagate to the outputs.
- The block does not check protocol: valid dropping without a handshake, or data changing while stalled, is passed through as-is.

Test Plan:
- Reset, then all req_valid=0 for 10 cycles -> out_valid=0, req_ready=0, grant_valid=0, grant_idx=0 throughout.
- N=2, req_valid=4'b1010 asserted together, single-beat packets, out_ready=1:
  - grants occur in order 1, 3, then 1 again (with req 1 re-asserted);
  - each out_data equals that requester's data (e.g. 0x11111111, 0x33333333);
  - one IDLE cycle precedes each grant.
- Requester 2 sends a 3-beat packet (0xA0, 0xA1, 0xA2, last on third) while req 0 is also valid. out_ready toggles 1,0,1,0,1 -> exactly 3 transfers in order, grant_idx=2 held throughout, req_ready[0]=0 throughout, then req 0 is granted.
- Holder 0 drops req_valid for 4 cycles mid-packet while req 1 is valid -> out_valid=0 for those cycles, grant_idx stays 0, req 1 is not granted until req 0's last beat transfers.
- All four requesters held continuously valid with 1-beat packets:
  - grant sequence is 0,1,2,3,0,1, so the rr pointer wraps from 3 to 0;
  - no requester waits more than 4 arbitrations.
- rst_n pulled low for 1 cycle during BUSY (grant_idx=3, beat 2 of 4) -> next cycle is IDLE with out_valid=0 and req_ready=0. With all requesters then valid, index 0 is granted first (ptr=0).
